// File: rtl/qmca_clk_pkg.sv
// Shared types and helpers for the QMCA lock-qualified clock/strobe generator.
package qmca_clk_pkg;

    // Top-level sequencing states.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_ALIGN     = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    // Widest divide/high/phase field the config record can carry.
    // Narrower CNT_WIDTH values are zero-extended into it.
    localparam int CFG_FIELD_W = 16;

    localparam logic [CFG_FIELD_W-1:0] FIELD_ONE = CFG_FIELD_W'(1);

    typedef struct packed {
        logic [CFG_FIELD_W-1:0] div;
        logic [CFG_FIELD_W-1:0] high;
        logic [CFG_FIELD_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_DISABLED = '0;

    // A channel config is usable when it disables the channel, or when it
    // describes a period of at least two cycles with a high time that leaves
    // at least one low cycle and a start phase inside the period.
    function automatic logic cfg_valid(input cfg_t c);
        logic ok;
        ok = 1'b0;
        if (c.div == '0) begin
            ok = 1'b1;
        end else if ((c.div > FIELD_ONE) && (c.high != '0) &&
                     (c.high < c.div) && (c.phase < c.div)) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/qmca_clk_div_ch.sv
// One divided-clock channel: period counter plus registered CLK/STB outputs.
module qmca_clk_div_ch
    import qmca_clk_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 align_i,
    input  logic                 run_i,
    input  logic [CNT_WIDTH-1:0] ld_div_i,
    input  logic [CNT_WIDTH-1:0] ld_phase_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] high_i,
    output logic                 clk_o,
    output logic                 stb_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 clk_q;
    logic                 stb_q;
    logic                 en;

    // A disabled channel never advances and never drives its outputs.
    assign en = run_i && (div_i != '0);

    // Next counter value: reload the start phase at alignment (zero for a
    // channel being disabled), otherwise wrap at div-1 while running.
    always_comb begin
        cnt_d = cnt_q;
        if (align_i) begin
            cnt_d = (ld_div_i == '0) ? '0 : ld_phase_i;
        end else if (en) begin
            cnt_d = (cnt_q == (div_i - CNT_WIDTH'(1))) ? '0 : (cnt_q + CNT_WIDTH'(1));
        end
    end

    // Counter and output registers; outputs lag the counter by one cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= en && (cnt_q < high_i);
            stb_q <= en && (cnt_q == '0);
        end
    end

    assign clk_o = clk_q;
    assign stb_o = stb_q;

endmodule

// File: rtl/qmca_clk_div_gen.sv
// Lock-qualified multi-channel clock/strobe generator: lock synchroniser,
// lock-delay counter, sequencing FSM, shadow/active config and channel array.
module qmca_clk_div_gen
    import qmca_clk_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8,
    parameter int LOCK_DLY  = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 LOCKED_IN,
    input  logic                 CFG_WR,
    input  logic [CH_W-1:0]      CFG_CH,
    input  logic [CNT_WIDTH-1:0] CFG_DIV,
    input  logic [CNT_WIDTH-1:0] CFG_HIGH,
    input  logic [CNT_WIDTH-1:0] CFG_PHASE,
    input  logic                 CFG_APPLY,
    output logic [CHANNELS-1:0]  CLK_OUT,
    output logic [CHANNELS-1:0]  STB,
    output logic                 READY,
    output logic                 CFG_ERR
);

    localparam int LC_W = $clog2(LOCK_DLY + 1);

    logic                 lock_s1_q;
    logic                 lock_s2_q;
    logic                 lock_sync;
    state_t               state_q;
    logic [LC_W-1:0]      lock_cnt_q;
    logic                 ready_q;
    logic                 cfg_err_q;
    logic                 cfg_err_d;
    cfg_t                 wr_cfg;
    logic                 wr_ok;
    logic                 run_stay;
    logic                 align;

    // Shadow holds written-but-not-applied settings. Active keeps only div and
    // high: phase is consumed straight from the shadow at alignment.
    logic [CNT_WIDTH-1:0] sh_div_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] sh_high_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] sh_phase_q [CHANNELS];
    logic [CNT_WIDTH-1:0] act_div_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] act_high_q [CHANNELS];

    // Two-flop synchroniser for the asynchronous DCM lock.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= LOCKED_IN;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign lock_sync = lock_s2_q;

    // Sequencer: wait for a stable lock, align once, then run until lock
    // loss (which wins) or an apply request.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_WAIT_LOCK;
            lock_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    ready_q <= 1'b0;
                    if (!lock_sync) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LC_W'(LOCK_DLY - 1)) begin
                        lock_cnt_q <= '0;
                        state_q    <= ST_ALIGN;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LC_W'(1);
                    end
                end
                ST_ALIGN: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
                ST_RUN: begin
                    if (!lock_sync) begin
                        state_q    <= ST_WAIT_LOCK;
                        lock_cnt_q <= '0;
                        ready_q    <= 1'b0;
                    end else if (CFG_APPLY) begin
                        state_q <= ST_ALIGN;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_WAIT_LOCK;
                    lock_cnt_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // Widen the incoming write into the shared config record for validation.
    always_comb begin
        wr_cfg = CFG_DISABLED;
        wr_cfg.div[CNT_WIDTH-1:0]   = CFG_DIV;
        wr_cfg.high[CNT_WIDTH-1:0]  = CFG_HIGH;
        wr_cfg.phase[CNT_WIDTH-1:0] = CFG_PHASE;
    end

    assign wr_ok     = CFG_WR && (int'(CFG_CH) < CHANNELS) && cfg_valid(wr_cfg);
    assign cfg_err_d = CFG_WR && !wr_ok;

    // Shadow writes, shadow-to-active copy at alignment, and the reject pulse.
    // A write in the cycle before ALIGN (including one paired with the apply
    // strobe) is already in the shadow when ALIGN copies it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sh_div_q[i]   <= '0;
                sh_high_q[i]  <= '0;
                sh_phase_q[i] <= '0;
                act_div_q[i]  <= '0;
                act_high_q[i] <= '0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (state_q == ST_ALIGN) begin
                    act_div_q[i]  <= sh_div_q[i];
                    act_high_q[i] <= sh_high_q[i];
                end
                if (wr_ok && (int'(CFG_CH) == i)) begin
                    sh_div_q[i]   <= CFG_DIV;
                    sh_high_q[i]  <= CFG_HIGH;
                    sh_phase_q[i] <= CFG_PHASE;
                end
            end
            cfg_err_q <= cfg_err_d;
        end
    end

    // Channels advance and drive outputs only on RUN cycles that stay in RUN,
    // so outputs read 0 from the first cycle after RUN is left.
    assign run_stay = (state_q == ST_RUN) && lock_sync && !CFG_APPLY;
    assign align    = (state_q == ST_ALIGN);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        qmca_clk_div_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .align_i    (align),
            .run_i      (run_stay),
            .ld_div_i   (sh_div_q[g]),
            .ld_phase_i (sh_phase_q[g]),
            .div_i      (act_div_q[g]),
            .high_i     (act_high_q[g]),
            .clk_o      (CLK_OUT[g]),
            .stb_o      (STB[g])
        );
    end

    assign READY   = ready_q;
    assign CFG_ERR = cfg_err_q;

endmodule

// File: tb/tb_qmca_clk_div_gen.sv
// Self-checking bench for qmca_clk_div_gen: per-cycle behavioural model plus
// directed literal checks and a randomized phase.
module tb_qmca_clk_div_gen;

    localparam int CH   = 3;
    localparam int CW   = 8;
    localparam int LD   = 4;
    localparam int CH_W = 2;
    localparam int MW   = 0;   // model: waiting for lock
    localparam int MA   = 1;   // model: aligning
    localparam int MR   = 2;   // model: running

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            LOCKED_IN;
    logic            CFG_WR;
    logic [CH_W-1:0] CFG_CH;
    logic [CW-1:0]   CFG_DIV;
    logic [CW-1:0]   CFG_HIGH;
    logic [CW-1:0]   CFG_PHASE;
    logic            CFG_APPLY;
    logic [CH-1:0]   CLK_OUT;
    logic [CH-1:0]   STB;
    logic            READY;
    logic            CFG_ERR;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    qmca_clk_div_gen #(
        .CHANNELS  (CH),
        .CNT_WIDTH (CW),
        .LOCK_DLY  (LD)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .LOCKED_IN (LOCKED_IN),
        .CFG_WR    (CFG_WR),
        .CFG_CH    (CFG_CH),
        .CFG_DIV   (CFG_DIV),
        .CFG_HIGH  (CFG_HIGH),
        .CFG_PHASE (CFG_PHASE),
        .CFG_APPLY (CFG_APPLY),
        .CLK_OUT   (CLK_OUT),
        .STB       (STB),
        .READY     (READY),
        .CFG_ERR   (CFG_ERR)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outputs are derived from elapsed run time: position in period =
    // (phase + cycles since first RUN cycle) mod div.
    int m_mode = MW;
    int m_hc   = 0;
    int m_age  = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    int sh_div[CH], sh_high[CH], sh_ph[CH];
    int ac_div[CH], ac_high[CH], ac_ph[CH];
    bit e_ready = 1'b0;
    bit e_err   = 1'b0;
    logic [CH-1:0] e_clk = '0;
    logic [CH-1:0] e_stb = '0;

    always @(posedge CLK) begin
        bit sync, stay, ok;
        int nmode, pos, d, h, p, c;
        if (RST_N !== 1'b1) begin
            m_mode = MW; m_hc = 0; m_age = 0; m_s1 = 0; m_s2 = 0;
            for (int i = 0; i < CH; i++) begin
                sh_div[i] = 0; sh_high[i] = 0; sh_ph[i] = 0;
                ac_div[i] = 0; ac_high[i] = 0; ac_ph[i] = 0;
            end
            e_ready = 0; e_err = 0; e_clk = '0; e_stb = '0;
        end else begin
            sync  = m_s2;
            stay  = (m_mode == MR) && sync && !CFG_APPLY;
            for (int i = 0; i < CH; i++) begin
                if (stay && ac_div[i] != 0) begin
                    pos = (ac_ph[i] + m_age) % ac_div[i];
                    e_clk[i] = (pos < ac_high[i]);
                    e_stb[i] = (pos == 0);
                end else begin
                    e_clk[i] = 1'b0;
                    e_stb[i] = 1'b0;
                end
            end
            nmode = m_mode;
            case (m_mode)
                MW: begin
                    if (sync) begin
                        m_hc++;
                        if (m_hc == LD) begin nmode = MA; m_hc = 0; end
                    end else m_hc = 0;
                end
                MA: begin
                    for (int i = 0; i < CH; i++) begin
                        ac_div[i] = sh_div[i]; ac_high[i] = sh_high[i]; ac_ph[i] = sh_ph[i];
                    end
                    m_age = 0;
                    nmode = MR;
                end
                default: begin
                    if (!sync) begin nmode = MW; m_hc = 0; end
                    else if (CFG_APPLY) nmode = MA;
                    else m_age++;
                end
            endcase
            m_mode  = nmode;
            e_ready = (nmode == MR);
            e_err   = 1'b0;
            if (CFG_WR) begin
                c = int'(CFG_CH); d = int'(CFG_DIV); h = int'(CFG_HIGH); p = int'(CFG_PHASE);
                ok = (c < CH) && ((d == 0) || (d >= 2 && h >= 1 && h <= d - 1 && p <= d - 1));
                if (ok) begin sh_div[c] = d; sh_high[c] = h; sh_ph[c] = p; end
                else e_err = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = LOCKED_IN;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ready",   {31'b0, READY},   {31'b0, e_ready});
            chk("clk_out", {29'b0, CLK_OUT}, {29'b0, e_clk});
            chk("stb",     {29'b0, STB},     {29'b0, e_stb});
            chk("cfg_err", {31'b0, CFG_ERR}, {31'b0, e_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input int ch, input int d, input int h, input int p);
        CFG_CH = CH_W'(ch); CFG_DIV = CW'(d); CFG_HIGH = CW'(h); CFG_PHASE = CW'(p);
        CFG_WR = 1'b1;
        @(negedge CLK);
        CFG_WR = 1'b0;
    endtask

    task automatic apply();
        CFG_APPLY = 1'b1;
        @(negedge CLK);
        CFG_APPLY = 1'b0;
    endtask

    initial begin
        int hi, sb, bad, n0, n1;
        logic [15:0] s0, s1;
        RST_N = 0; LOCKED_IN = 0; CFG_WR = 0; CFG_APPLY = 0;
        CFG_CH = '0; CFG_DIV = '0; CFG_HIGH = '0; CFG_PHASE = '0;
        cyc(2);
        chk_en = 1'b1;
        cyc(1);
        chk("reset_ready", {31'b0, READY}, 32'd0);
        chk("reset_clk",   {29'b0, CLK_OUT}, 32'd0);
        chk("reset_err",   {31'b0, CFG_ERR}, 32'd0);

        // Lock-up latency: READY first seen 2 + LOCK_DLY + 1 cycles after lock.
        RST_N = 1; LOCKED_IN = 1;
        cyc(6);
        chk("lock_lat_pre", {31'b0, READY}, 32'd0);
        cyc(1);
        chk("lock_lat", {31'b0, READY}, 32'd1);
        chk("disabled_clk", {29'b0, CLK_OUT}, 32'd0);

        // ADC_ENC style: 16/8/0 on ch0.
        wr(0, 16, 8, 0);
        chk("wr_ok_err", {31'b0, CFG_ERR}, 32'd0);
        apply();
        cyc(2);
        chk("first_rise", {31'b0, CLK_OUT[0]}, 32'd1);
        chk("first_stb",  {31'b0, STB[0]},     32'd1);
        hi = 0; sb = 0;
        for (int k = 0; k < 32; k++) begin
            hi += int'(CLK_OUT[0]); sb += int'(STB[0]);
            @(negedge CLK);
        end
        chk("div16_high", hi, 32'd16);
        chk("div16_stb",  sb, 32'd2);

        // Phase offset between two channels.
        wr(0, 4, 2, 0);
        wr(1, 4, 1, 2);
        apply();
        cyc(2);
        for (int k = 0; k < 16; k++) begin
            s0[k] = STB[0]; s1[k] = STB[1];
            @(negedge CLK);
        end
        bad = 0; n0 = 0; n1 = 0;
        for (int k = 0; k < 16; k++) begin
            n0 += int'(s0[k]); n1 += int'(s1[k]);
            if (k >= 2 && s1[k] != s0[k-2]) bad++;
        end
        chk("phase_off", bad, 32'd0);
        chk("phase_n0", n0, 32'd4);
        chk("phase_n1", n1, 32'd4);
        chk("phase_first", {31'b0, s1[2]}, 32'd1);

        // Invalid writes.
        wr(0, 1, 0, 0);  chk("inv_div1",  {31'b0, CFG_ERR}, 32'd1);
        wr(0, 8, 8, 0);  chk("inv_high",  {31'b0, CFG_ERR}, 32'd1);
        wr(0, 8, 4, 8);  chk("inv_phase", {31'b0, CFG_ERR}, 32'd1);
        wr(3, 4, 2, 0);  chk("inv_ch",    {31'b0, CFG_ERR}, 32'd1);
        cyc(1);
        chk("err_pulse_end", {31'b0, CFG_ERR}, 32'd0);
        apply();
        cyc(20);

        // Pending write, then a one-cycle lock glitch.
        wr(2, 6, 3, 1);
        cyc(3);
        LOCKED_IN = 0;
        cyc(1);
        LOCKED_IN = 1;
        cyc(2);
        chk("glitch_ready", {31'b0, READY}, 32'd0);
        chk("glitch_clk", {29'b0, CLK_OUT}, 32'd0);
        cyc(5);
        chk("relock_ready", {31'b0, READY}, 32'd1);
        cyc(24);

        // Write and apply in the same cycle.
        CFG_CH = 0; CFG_DIV = 5; CFG_HIGH = 2; CFG_PHASE = 0;
        CFG_WR = 1; CFG_APPLY = 1;
        @(negedge CLK);
        CFG_WR = 0; CFG_APPLY = 0;
        cyc(2);
        hi = 0; sb = 0;
        for (int k = 0; k < 10; k++) begin
            hi += int'(CLK_OUT[0]); sb += int'(STB[0]);
            @(negedge CLK);
        end
        chk("wa_high", hi, 32'd4);
        chk("wa_stb",  sb, 32'd2);

        // Reset mid-period.
        cyc(2);
        RST_N = 0;
        cyc(1);
        chk("mid_rst_ready", {31'b0, READY}, 32'd0);
        chk("mid_rst_clk",   {29'b0, CLK_OUT}, 32'd0);
        chk("mid_rst_stb",   {29'b0, STB}, 32'd0);
        RST_N = 1;
        cyc(6);
        chk("rst_relock_pre", {31'b0, READY}, 32'd0);
        cyc(1);
        chk("rst_relock", {31'b0, READY}, 32'd1);
        cyc(3);
        chk("rst_cfg_cleared", {29'b0, CLK_OUT}, 32'd0);

        // Randomized operation mix against the model.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
            end else if (r == 4) begin
                apply();
            end else if (r == 5) begin
                CFG_CH = CH_W'($urandom_range(0, 2)); CFG_DIV = CW'($urandom_range(2, 9));
                CFG_HIGH = 1; CFG_PHASE = 0;
                CFG_WR = 1; CFG_APPLY = 1;
                @(negedge CLK);
                CFG_WR = 0; CFG_APPLY = 0;
            end else if (r == 6) begin
                LOCKED_IN = 0;
                cyc(int'($urandom_range(1, 3)));
                LOCKED_IN = 1;
            end
            cyc(int'($urandom_range(1, 8)));
        end
        cyc(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
